spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side counterpart to the LIF neuron: converts a spike train back into numeric values. It counts spikes over a fixed window of enabled cycles and presents each window's count through a single-entry valid/ready output register. It optionally reports the most recent inter-spike interval. It sits downstream of a neuron's `spike` output and feeds readout or coupling logic.

## Interface
- `WINDOW`, default 64: window length in enabled (`ena`=1) cycles; legal range 2..256.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  count enable; freezes all counting when low
- `spike_in`  in  1  spike level; each enabled cycle with `spike_in`=1 counts as one spike
- `out_ready`  in  1  consumer accepts result
- `out_valid`  out  1  result register holds an unconsumed result
- `out_count`  out  8  spikes in the completed window, saturating at 255
- `out_overflow`  out  1  count saturated in that window
- `out_lost`  out  1  this result overwrote an unconsumed previous result
- `out_isi`  out  8  last inter-spike interval in enabled cycles; 0 if none measured

## Operation
- **Window counter** (8 bit) increments on every enabled cycle and wraps from WINDOW-1 to 0.
  - The cycle where it equals WINDOW-1 is the window's closing cycle.
  - Windows are back-to-back, with no dead cycles.
- **Spike counter** (8 bit) increments on enabled cycles with `spike_in`=1 and saturates at 255.
  - A sticky overflow flag is set on any attempted increment at 255.
- **Closing cycle**, when enabled:
  - The result is `count` plus the closing cycle's own spike, saturated; overflow is computed the same way.
  - This result loads the output register.
  - The spike counter and overflow flag clear for the new window.
- **Output register** has two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - Transfer occurs when `out_valid` & `out_ready`.
  - Load with no transfer: the state goes FULL. `out_lost`=1 if the register was FULL before the load, else 0.
  - Transfer with no load: the state goes EMPTY, and the data outputs hold their last values.
  - Load and transfer in the same cycle: the new result loads, the state stays FULL, and `out_lost`=0.
- **When `ena`=0:**
  - The window counter, spike counter, and ISI logic hold, and `spike_in` is ignored.
  - The output handshake still operates normally.
- **Reset** clears every register and returns the output register to EMPTY. A reset mid-window discards the partial window.
- The output data fields are only meaningful while `out_valid`=1.

## Timing
- Reset values:
  - `out_valid`=0, `out_count`=0, `out_overflow`=0, `out_lost`=0, `out_isi`=0.
  - Internal counters are 0, and the ISI seen-flag is 0.
- Result latency: `out_valid` rises on the clock edge that ends the closing cycle. With `ena` held high, the first result is visible WINDOW cycles after reset release.
- `out_valid` is registered and never depends combinationally on `out_ready`.
- `out_valid`=1 persists until a transfer; the data outputs are stable while `out_valid`=1 and no load occurs.

## Configuration
- Macro: `SPIKE_ISI_EN`.
- **With the macro defined:**
  - An 8-bit ISI counter increments on enabled non-spike cycles, saturating at 255.
  - On an enabled spike cycle:
    - If a previous spike has been seen, the measured interval is the counter value + 1, saturated to 255.
    - The counter then resets to 0 and the seen-flag is set.
  - Spikes on consecutive enabled cycles give an interval of 1.
  - The ISI counter spans window boundaries.
  - At each load, `out_isi` takes the last measured interval, or 0 if fewer than two spikes have occurred since reset.
- **Without the macro:**
  - No ISI logic is synthesised.
  - The `out_isi` port remains and is tied to 0.

## Test plan
- WINDOW=64, `ena`=1, `spike_in`=1 constantly, `out_ready`=1 -> first `out_valid` pulse 64 cycles after reset; repeats every 64 cycles with `out_count`=64, `out_overflow`=0, `out_lost`=0, `out_isi`=1 (with the macro).
- Spike every 4th enabled cycle, WINDOW=64 -> `out_count`=16 each window; `out_isi`=4 with the macro, 0 without.
- `out_ready`=0 across two closings -> the second result has `out_lost`=1 and `out_valid` stays 1; raising `out_ready` drops `out_valid` next cycle. Also drive a load and a transfer in the same cycle -> `out_lost`=0 and `out_valid` stays 1.
- `ena` toggling 1/0 each cycle with `spike_in`=1 -> each window spans 128 clocks and `out_count`=64; spikes during `ena`=0 are not counted.
- WINDOW=256, `spike_in`=1 constantly -> `out_count`=255, `out_overflow`=1; the next window restarts cleanly.
- Assert `rst_n` low mid-window with `out_valid`=1 -> all outputs become 0 immediately; after release, the first result arrives a full WINDOW later, and `out_isi`=0 until two new spikes occur.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-count rate decoder: per-window spike totals through a valid/ready register.
// Optional inter-spike interval reporting is enabled by defining SPIKE_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_count,
  output logic       out_overflow,
  output logic       out_lost,
  output logic [7:0] out_isi
);

  localparam logic [7:0] LAST = 8'(WINDOW - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] win_cnt;
  logic [7:0] spk_cnt;
  logic       ovf;
  logic [7:0] res_cnt;
  logic       res_ovf;
  logic       closing;
  logic       load;
  logic       xfer;

  assign closing   = (win_cnt == LAST);
  assign load      = ena & closing;
  assign out_valid = (state == FULL);
  assign xfer      = out_valid & out_ready;

  // Count including this cycle's spike, saturated, with sticky overflow.
  always_comb begin
    res_cnt = spk_cnt;
    res_ovf = ovf;
    if (spike_in) begin
      if (spk_cnt == 8'hFF) begin
        res_ovf = 1'b1;
      end else begin
        res_cnt = spk_cnt + 8'd1;
      end
    end
  end

  // Window position; wraps on the closing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (ena) begin
      win_cnt <= closing ? 8'd0 : win_cnt + 8'd1;
    end
  end

  // Spike accumulator, cleared when a window closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_cnt <= '0;
      ovf     <= 1'b0;
    end else if (ena) begin
      if (closing) begin
        spk_cnt <= '0;
        ovf     <= 1'b0;
      end else begin
        spk_cnt <= res_cnt;
        ovf     <= res_ovf;
      end
    end
  end

  // Output register occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // A load always wins; a transfer alone empties the register.
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = FULL;
    end else if (xfer) begin
      state_nx = EMPTY;
    end
  end

  // Result data; held across transfers until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_lost     <= 1'b0;
    end else if (load) begin
      out_count    <= res_cnt;
      out_overflow <= res_ovf;
      out_lost     <= out_valid & ~out_ready;
    end
  end

`ifdef SPIKE_ISI_EN
  logic [7:0] isi_cnt;
  logic [7:0] isi_last;
  logic [7:0] isi_meas;
  logic [7:0] isi_load;
  logic       seen;

  // Interval ending now, and the value a load would capture.
  always_comb begin
    isi_meas = (isi_cnt == 8'hFF) ? 8'hFF : isi_cnt + 8'd1;
    isi_load = isi_last;
    if (ena && spike_in && seen) begin
      isi_load = isi_meas;
    end
  end

  // Interval timer; runs across window boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt  <= '0;
      isi_last <= '0;
      seen     <= 1'b0;
    end else if (ena) begin
      if (spike_in) begin
        if (seen) begin
          isi_last <= isi_meas;
        end
        isi_cnt <= '0;
        seen    <= 1'b1;
      end else if (isi_cnt != 8'hFF) begin
        isi_cnt <= isi_cnt + 8'd1;
      end
    end
  end

  // Interval snapshot taken with each result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_isi <= '0;
    end else if (load) begin
      out_isi <= isi_load;
    end
  end
`else
  assign out_isi = 8'd0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized scoreboard bench for spike_rate_decoder.
// Two instances (WINDOW 64 and 256) share one stimulus stream.
module tb_spike_rate_decoder;

  localparam int W0 = 64;
  localparam int W1 = 256;
`ifdef SPIKE_ISI_EN
  localparam bit ISI_EN = 1'b1;
`else
  localparam bit ISI_EN = 1'b0;
`endif

  typedef struct {
    int cnt;
    bit ovf;
    bit lost;
    int isi;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       ov [2];
  logic       oovf [2];
  logic       olost [2];
  logic [7:0] oc [2];
  logic [7:0] oi [2];

  int   checks = 0;
  int   failures = 0;

  res_t q [2][$];
  int   wlen [2] = '{W0, W1};
  int   n [2];
  int   wspk [2];
  int   ps [2];
  int   isi [2];
  bit   seen [2];
  bit   mv [2];

  spike_rate_decoder #(.WINDOW(W0)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .spike_in(spike_in), .out_ready(out_ready),
    .out_valid(ov[0]), .out_count(oc[0]),
    .out_overflow(oovf[0]), .out_lost(olost[0]),
    .out_isi(oi[0])
  );

  spike_rate_decoder #(.WINDOW(W1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .spike_in(spike_in), .out_ready(out_ready),
    .out_valid(ov[1]), .out_count(oc[1]),
    .out_overflow(oovf[1]), .out_lost(olost[1]),
    .out_isi(oi[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0d required=%0d t=%0t",
               name, idx, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle timestamps and plain spike tallies.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      bit   xfer;
      bit   load;
      res_t r;
      if (!rst_n) begin
        n[i] = 0; wspk[i] = 0; ps[i] = 0;
        isi[i] = 0; seen[i] = 0; mv[i] = 0;
        q[i].delete();
      end else begin
        xfer = mv[i] && out_ready;
        load = 0;
        r = '{0, 0, 0, 0};
        if (ena) begin
          if (spike_in) begin
            wspk[i]++;
            if (seen[i])
              isi[i] = (n[i] - ps[i] > 255) ? 255 : n[i] - ps[i];
            ps[i] = n[i];
            seen[i] = 1;
          end
          if ((n[i] + 1) % wlen[i] == 0) begin
            load = 1;
            r.cnt = (wspk[i] > 255) ? 255 : wspk[i];
            r.ovf = (wspk[i] > 255);
            r.isi = ISI_EN ? isi[i] : 0;
            wspk[i] = 0;
          end
          n[i]++;
        end
        if (load) begin
          r.lost = mv[i] && !xfer;
          if (r.lost && q[i].size() > 0) void'(q[i].pop_back());
          q[i].push_back(r);
          mv[i] = 1;
        end else if (xfer) begin
          mv[i] = 0;
        end
      end
    end
  end

  // Monitor: occupancy every cycle, data at each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, int'(ov[i]), int'(mv[i]));
        if (ov[i] && out_ready) begin
          if (q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop inst%0d actual=transfer required=no_result t=%0t",
                     i, $time);
          end else begin
            res_t e;
            e = q[i].pop_front();
            chk("count", i, int'(oc[i]), e.cnt);
            chk("overflow", i, int'(oovf[i]), int'(e.ovf));
            chk("lost", i, int'(olost[i]), int'(e.lost));
            chk("isi", i, int'(oi[i]), e.isi);
          end
        end
      end
    end
  end

  task automatic step(input bit e, input bit s, input bit r);
    ena = e;
    spike_in = s;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic zero_chk();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, int'(ov[i]), 0);
      chk("rst_count", i, int'(oc[i]), 0);
      chk("rst_ovf", i, int'(oovf[i]), 0);
      chk("rst_lost", i, int'(olost[i]), 0);
      chk("rst_isi", i, int'(oi[i]), 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    zero_chk();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    zero_chk();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Constant spiking: 64 per short window, saturation on the long one.
    for (int c = 0; c < 600; c++) step(1, 1, 1);

    // Every 4th enabled cycle spikes.
    do_reset();
    for (int c = 0; c < 300; c++) step(1, (c % 4) == 3, 1);

    // Stalled consumer across two closings, then drain.
    for (int c = 0; c < 140; c++) step(1, $urandom_range(0, 1) == 1, 0);
    for (int c = 0; c < 10; c++) step(1, 1, 1);

    // Enable toggling every cycle with spike held high.
    do_reset();
    for (int c = 0; c < 400; c++) step((c % 2) == 0, 1, 1);

    // Random traffic with varying density and back-pressure.
    for (int seg = 0; seg < 30; seg++) begin
      int dens;
      int rdy;
      dens = $urandom_range(0, 100);
      rdy = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++)
        step($urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < dens,
             $urandom_range(0, 99) < rdy);
    end

    // Reset mid-window while a result is pending.
    do_reset();
    for (int c = 0; c < 70; c++) step(1, 1, 0);
    chk("pending", 0, int'(ov[0]), 1);
    do_reset();
    for (int c = 0; c < 200; c++) step(1, c == 10 || c == 100, 1);
    for (int c = 0; c < 300; c++) step(1, (c % 3) == 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
